// File: rtl/fetch_pc.sv
// Fetch-stage PC sequencer: issues instruction-memory fetches, registers each word
// and its PC for decode, and applies taken-branch redirects after the delay slot.
module fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic        inst_valid
);
    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        accept;
    logic        redir;
    logic [31:0] next_pc;

    // Gating with rst keeps the request low through reset, before state is known.
    assign imem_req  = !rst && (state == RUN) && (!stall || !inst_valid);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    assign redir     = br_valid && br_taken;

    // NOTE: next_pc gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_pc = pc + 32'd4;
        if (pend_valid) begin
            next_pc = pend_target;
        end else if (redir) begin
            next_pc = br_target;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            inst        <= 32'd0;
            pc_out      <= 32'd0;
            inst_valid  <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
        end else begin
            state <= RUN;
            if (accept) begin
                inst       <= imem_rdata;
                pc_out     <= pc;
                inst_valid <= 1'b1;
                pc         <= next_pc;
                pend_valid <= 1'b0;
            end else begin
                if (!stall) begin
                    inst_valid <= 1'b0;
                end
                // A redirect seen while already pending is dropped: the first target wins.
                if (redir && !pend_valid) begin
                    pend_valid  <= 1'b1;
                    pend_target <= br_target;
                end
            end
        end
    end
endmodule
